// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared FSM state, grant select type and tie-break helper
// Contents:
//   arb_state_t - arbiter FSM states IDLE / SERVE_I / SERVE_D
//   arb_sel_t   - which requester a decision refers to (SEL_I / SEL_D)
//   pick()      - winner for the current request pair; on a tie the side
//                 other than last_grant wins, so a constant SEL_I gives
//                 fixed dcache priority
package cache_arb_pkg;

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;

    typedef enum logic {SEL_I, SEL_D} arb_sel_t;

    function automatic arb_sel_t pick(input logic i_req, input logic d_req, input arb_sel_t last_grant);
        return (i_req && d_req) ? ((last_grant == SEL_I) ? SEL_D : SEL_I) : (d_req ? SEL_D : SEL_I);
    endfunction

endpackage

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical-memory port between icache and dcache
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   i_pmem_*            - icache side: read/write/address/wdata in, rdata/resp out
//   d_pmem_*            - dcache side: read/write/address/wdata in, rdata/resp out
//   pmem_*              - memory side: read/write/address/wdata out, rdata/resp in
// Configuration:
//   ARB_ROUND_ROBIN_EN  - defined: ties alternate via a last_grant register
//                         undefined: dcache always wins ties
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pmem_read,
    input  logic              i_pmem_write,
    input  logic [ADDR_W-1:0] i_pmem_address,
    input  logic [LINE_W-1:0] i_pmem_wdata,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t state_q, state_d;
    arb_sel_t   last_grant, win;
    logic       i_pend, d_pend;

    assign i_pend = i_pmem_read | i_pmem_write;
    assign d_pend = d_pmem_read | d_pmem_write;
    assign win    = pick(i_pend, d_pend, last_grant);

`ifdef ARB_ROUND_ROBIN_EN
    arb_sel_t last_grant_q, last_grant_d;

    // Remember who was granted at the moment a SERVE state is entered
    always_comb last_grant_d = (state_q == IDLE && state_d != IDLE) ? win : last_grant_q;

    always_ff @(posedge clk) last_grant_q <= !rst_n ? SEL_I : last_grant_d;

    assign last_grant = last_grant_q;
`else
    // Constant SEL_I makes pick() hand every tie to the dcache
    assign last_grant = SEL_I;
`endif

    always_ff @(posedge clk) state_q <= !rst_n ? IDLE : state_d;

    // Every completion returns to IDLE, guaranteeing one idle cycle between grants
    always_comb begin
        state_d = (state_q == IDLE) ? ((i_pend | d_pend) ? ((win == SEL_D) ? SERVE_D : SERVE_I) : IDLE)
                                    : (pmem_resp ? IDLE : state_q);
    end

    always_comb begin
        pmem_read    = (state_q == SERVE_I) ? i_pmem_read    : (state_q == SERVE_D) ? d_pmem_read    : 1'b0;
        pmem_write   = (state_q == SERVE_I) ? i_pmem_write   : (state_q == SERVE_D) ? d_pmem_write   : 1'b0;
        pmem_address = (state_q == SERVE_I) ? i_pmem_address : (state_q == SERVE_D) ? d_pmem_address : '0;
        pmem_wdata   = (state_q == SERVE_I) ? i_pmem_wdata   : (state_q == SERVE_D) ? d_pmem_wdata   : '0;
        i_pmem_resp  = (state_q == SERVE_I) & pmem_resp;
        d_pmem_resp  = (state_q == SERVE_D) & pmem_resp;
    end

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: scoreboard bench for cache_arbiter with a fixed-latency memory model
module tb_cache_arbiter;

    localparam int AW  = 32;
    localparam int LW  = 256;
    localparam int LAT = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic          rd;
        logic          wr;
        logic [LW-1:0] wd;
    } grant_t;

    typedef struct packed {
        logic          d;
        logic [LW-1:0] rd;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_pmem_read = 1'b0, i_pmem_write = 1'b0;
    logic [AW-1:0] i_pmem_address = '0;
    logic [LW-1:0] i_pmem_wdata = '0;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read = 1'b0, d_pmem_write = 1'b0;
    logic [AW-1:0] d_pmem_address = '0;
    logic [LW-1:0] d_pmem_wdata = '0;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read, pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;
    logic          stray = 1'b0;

    grant_t eg[$];
    resp_t  er[$];
    int     n_chk = 0;
    int     n_fail = 0;

    localparam logic [LW-1:0] WB_LINE = {16{16'h1234}};

    cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write), .i_pmem_address(i_pmem_address),
        .i_pmem_wdata(i_pmem_wdata), .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write), .d_pmem_address(d_pmem_address),
        .d_pmem_wdata(d_pmem_wdata), .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        return (a == 32'h0000_1040) ? {32{8'hA5}} : {8{a}};
    endfunction

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_g(input logic [AW-1:0] a, input logic rd, input logic wr, input logic [LW-1:0] wd);
        grant_t g;
        g.a = a; g.rd = rd; g.wr = wr; g.wd = wd;
        eg.push_back(g);
    endtask

    task automatic push_r(input logic d, input logic [LW-1:0] rd);
        resp_t r;
        r.d = d; r.rd = rd;
        er.push_back(r);
    endtask

    // Responds LAT cycles after a command appears; a stray flag injects a lone resp pulse
    task automatic mem_model();
        int cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pmem_resp = 1'b0;
                cnt = 0;
            end else if (pmem_resp) begin
                pmem_resp = 1'b0;
                cnt = 0;
            end else if (stray) begin
                pmem_resp = 1'b1;
                stray = 1'b0;
            end else if (pmem_read | pmem_write) begin
                cnt++;
                if (cnt == LAT) begin
                    pmem_rdata = line_of(pmem_address);
                    pmem_resp = 1'b1;
                end
            end
        end
    endtask

    task automatic monitor();
        logic   pc = 1'b0;
        grant_t g;
        resp_t  r;
        forever begin
            @(negedge clk);
            if ((pmem_read | pmem_write) && !pc) begin
                if (eg.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_grant: got addr %0h expected none", pmem_address);
                end else begin
                    g = eg.pop_front();
                    chk("grant_addr", pmem_address, g.a);
                    chk("grant_cmd", {pmem_read, pmem_write}, {g.rd, g.wr});
                    chk("grant_wdata", pmem_wdata, g.wd);
                end
            end
            pc = pmem_read | pmem_write;
            if (i_pmem_resp | d_pmem_resp) begin
                if (er.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_resp: got i=%0b d=%0b expected none", i_pmem_resp, d_pmem_resp);
                end else begin
                    r = er.pop_front();
                    chk("resp_sel", {i_pmem_resp, d_pmem_resp}, r.d ? 2'b01 : 2'b10);
                    chk("resp_rdata", r.d ? d_pmem_rdata : i_pmem_rdata, r.rd);
                end
            end
        end
    endtask

    // Must be called #1 after a rising edge; returns #1 after the edge that ends SERVE
    task automatic req(input logic d, input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] wd);
        if (d) begin
            d_pmem_read = !wr; d_pmem_write = wr; d_pmem_address = a; d_pmem_wdata = wd;
        end else begin
            i_pmem_read = !wr; i_pmem_write = wr; i_pmem_address = a; i_pmem_wdata = wd;
        end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (d ? d_pmem_resp : i_pmem_resp) break;
            if (k == 99) begin
                n_chk++; n_fail++;
                $display("FAIL req_timeout: got no resp for %0h expected resp", a);
            end
        end
        @(posedge clk);
        #1;
        if (d) begin
            d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        end else begin
            i_pmem_read = 1'b0; i_pmem_write = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_pmem_read = 1'b0; i_pmem_write = 1'b0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        fork
            mem_model();
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: got no finish expected finish");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_read", pmem_read, 0);
        chk("rst_write", pmem_write, 0);
        chk("rst_addr", pmem_address, 0);
        chk("rst_wdata", pmem_wdata, 0);
        chk("rst_iresp", i_pmem_resp, 0);
        chk("rst_dresp", d_pmem_resp, 0);

        // Reset in the middle of a dcache write-back
        do_reset();
        push_g(32'h300, 1'b0, 1'b1, WB_LINE);
        d_pmem_write = 1'b1; d_pmem_address = 32'h300; d_pmem_wdata = WB_LINE;
        repeat (2) @(negedge clk);
        chk("mid_write_granted", pmem_write, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_write", pmem_write, 0);
        chk("mid_rst_addr", pmem_address, 0);
        chk("mid_rst_wdata", pmem_wdata, 0);
        chk("mid_rst_dresp", d_pmem_resp, 0);
        d_pmem_write = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {pmem_read, pmem_write}, 0);

        // Lone icache read with grant latency check
        do_reset();
        push_g(32'h0000_1040, 1'b1, 1'b0, '0);
        push_r(1'b0, {32{8'hA5}});
        fork
            req(1'b0, 1'b0, 32'h0000_1040, '0);
            begin
                @(negedge clk);
                chk("lat_cycle_t", pmem_read, 0);
                @(negedge clk);
                chk("lat_cycle_t1", pmem_read, 1);
            end
        join

        // Simultaneous requests: dcache first in both modes right after reset
        do_reset();
        push_g(32'h200, 1'b1, 1'b0, '0);
        push_g(32'h100, 1'b1, 1'b0, '0);
        push_r(1'b1, line_of(32'h200));
        push_r(1'b0, line_of(32'h100));
        fork
            req(1'b0, 1'b0, 32'h100, '0);
            req(1'b1, 1'b0, 32'h200, '0);
        join

        // Write-back then line read from dcache with icache pending throughout
        do_reset();
        push_g(32'h300, 1'b0, 1'b1, WB_LINE);
        push_r(1'b1, line_of(32'h300));
`ifdef ARB_ROUND_ROBIN_EN
        push_g(32'h500, 1'b1, 1'b0, '0);
        push_g(32'h400, 1'b1, 1'b0, '0);
        push_r(1'b0, line_of(32'h500));
        push_r(1'b1, line_of(32'h400));
`else
        push_g(32'h400, 1'b1, 1'b0, '0);
        push_g(32'h500, 1'b1, 1'b0, '0);
        push_r(1'b1, line_of(32'h400));
        push_r(1'b0, line_of(32'h500));
`endif
        fork
            begin
                req(1'b1, 1'b1, 32'h300, WB_LINE);
                req(1'b1, 1'b0, 32'h400, '0);
            end
            req(1'b0, 1'b0, 32'h500, '0);
        join

        // Stray memory response while idle
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        chk("stray_resp_seen", pmem_resp, 1);
        chk("stray_iresp", i_pmem_resp, 0);
        chk("stray_dresp", d_pmem_resp, 0);
        @(negedge clk);
        chk("stray_idle", {pmem_read, pmem_write}, 0);

        repeat (3) @(negedge clk);
        chk("grants_left", eg.size(), 0);
        chk("resps_left", er.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
